// File: rtl/seq_1001_gen.sv
// Serial pattern transmitter: emits PATTERN MSB first rep_count times, with
// gap_len idle-zero bits between repetitions, then pulses done for one cycle.
module seq_1001_gen #(
    parameter logic [3:0] PATTERN = 4'b1001,
    parameter int         CNT_W   = 8,
    parameter int         GAP_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] rep_count,
    input  logic [GAP_W-1:0] gap_len,
    output logic             data_out,
    output logic             bit_valid,
    output logic             pattern_end,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [GAP_W-1:0] GAP_ZERO = GAP_W'(0);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    state_t           state_r, state_s;
    logic [1:0]       idx_r, idx_s;
    logic [CNT_W-1:0] remaining_r, remaining_s;
    logic [GAP_W-1:0] gap_len_r, gap_len_s;
    logic [GAP_W-1:0] gap_cnt_r, gap_cnt_s;
    logic             data_s, valid_s, pend_s, busy_s, done_s;

    // Next-state logic; outputs are derived from the next state so the
    // registered outputs always describe the bit currently on the line.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        remaining_s = remaining_r;
        gap_len_s   = gap_len_r;
        gap_cnt_s   = gap_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    remaining_s = rep_count;
                    gap_len_s   = gap_len;
                    gap_cnt_s   = GAP_ZERO;
                    idx_s       = 2'd3;
                    if (rep_count != CNT_ZERO) begin
                        state_s = ST_SEND;
                    end else begin
                        state_s = ST_FIN;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (idx_r != 2'd0) begin
                    idx_s = idx_r - 2'd1;
                end else begin
                    // Last bit of a pattern is on the line this cycle.
                    remaining_s = remaining_r - CNT_ONE;
                    idx_s       = 2'd3;
                    if (remaining_r == CNT_ONE) begin
                        state_s = ST_FIN;
                    end else if (gap_len_r == GAP_ZERO) begin
                        state_s = ST_SEND;
                    end else begin
                        state_s   = ST_GAP;
                        gap_cnt_s = gap_len_r;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_ONE) begin
                    state_s   = ST_SEND;
                    idx_s     = 2'd3;
                    gap_cnt_s = GAP_ZERO;
                end else begin
                    gap_cnt_s = gap_cnt_r - GAP_ONE;
                end
            end
            ST_FIN: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        data_s  = (state_s == ST_SEND) ? PATTERN[idx_s] : 1'b0;
        valid_s = (state_s == ST_SEND) || (state_s == ST_GAP);
        pend_s  = (state_s == ST_SEND) && (idx_s == 2'd0);
        busy_s  = valid_s;
        done_s  = (state_s == ST_FIN);
    end

    // State, counters and registered outputs; reset wins over start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            idx_r       <= 2'd0;
            remaining_r <= CNT_ZERO;
            gap_len_r   <= GAP_ZERO;
            gap_cnt_r   <= GAP_ZERO;
            data_out    <= 1'b0;
            bit_valid   <= 1'b0;
            pattern_end <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            remaining_r <= remaining_s;
            gap_len_r   <= gap_len_s;
            gap_cnt_r   <= gap_cnt_s;
            data_out    <= data_s;
            bit_valid   <= valid_s;
            pattern_end <= pend_s;
            busy        <= busy_s;
            done        <= done_s;
        end
    end

endmodule

// File: tb/tb_seq_1001_gen.sv
// Self-checking bench for seq_1001_gen: directed and random runs compared
// against an expected bit stream built from the pattern/gap rules.
module tb_seq_1001_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] rep_count;
    logic [3:0] gap_len;
    logic       data_out, bit_valid, pattern_end, busy, done;

    int         total = 0;
    int         bad   = 0;
    int         det;
    int         hn;
    logic [3:0] hist;

    always #5 clk = ~clk;

    seq_1001_gen dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .rep_count   (rep_count),
        .gap_len     (gap_len),
        .data_out    (data_out),
        .bit_valid   (bit_valid),
        .pattern_end (pattern_end),
        .busy        (busy),
        .done        (done)
    );

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] outs();
        return {27'd0, data_out, bit_valid, pattern_end, busy, done};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and let a non-overlapping 1001 detector observe the line.
    task automatic tick();
        @(posedge clk);
        #1;
        hist = {hist[2:0], data_out};
        hn++;
        if (hn >= 4 && hist == 4'b1001) begin
            det++;
            hn = 0;
        end
    endtask

    // One transmission: collide_at pulses start (R=9) during that busy cycle,
    // abort_at asserts reset during that cycle, fin_start pulses start during done.
    task automatic run(input int r, input int g, input int collide_at,
                       input int abort_at, input bit fin_start);
        logic [2:0] q[$];
        logic [3:0] pat;
        pat = 4'b1001;
        q.delete();
        for (int k = 0; k < r; k++) begin
            for (int b = 3; b >= 0; b--) q.push_back({pat[b], 1'b1, (b == 0)});
            if (k < r - 1) begin
                for (int z = 0; z < g; z++) q.push_back(3'b010);
            end
        end
        det  = 0;
        hn   = 0;
        hist = 4'b0000;

        start     = 1'b1;
        rep_count = r[7:0];
        gap_len   = g[3:0];
        tick();
        start     = 1'b0;
        rep_count = 8'($urandom);
        gap_len   = 4'($urandom);

        for (int i = 1; i <= q.size(); i++) begin
            check($sformatf("stream_r%0d_g%0d_c%0d", r, g, i), outs(), {27'd0, q[i-1], 2'b10});
            start = (i == collide_at);
            if (i == collide_at) rep_count = 8'd9;
            if (i == abort_at) reset = 1'b1;
            tick();
            start = 1'b0;
            if (i == abort_at) begin
                check("abort_outputs_zero", outs(), 32'd0);
                reset = 1'b0;
                tick();
                check("abort_no_done_1", outs(), 32'd0);
                tick();
                check("abort_no_done_2", outs(), 32'd0);
                return;
            end
        end

        start = fin_start;
        if (fin_start) rep_count = 8'd9;
        check($sformatf("done_r%0d_g%0d", r, g), outs(), 32'd1);
        check($sformatf("loopback_r%0d_g%0d", r, g), 32'(det), 32'(r));
        tick();
        start = 1'b0;
        check($sformatf("after_done_r%0d_g%0d", r, g), outs(), 32'd0);
        tick();
        check($sformatf("idle_r%0d_g%0d", r, g), outs(), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        rep_count = 8'd0;
        gap_len   = 4'd0;
        hist      = 4'b0000;
        hn        = 0;
        det       = 0;

        // Reset held three cycles with start toggling: nothing may move.
        for (int i = 0; i < 3; i++) begin
            start     = (i % 2 == 0);
            rep_count = 8'd3;
            tick();
            check($sformatf("reset_hold_%0d", i), outs(), 32'd0);
        end
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post_reset_idle_%0d", i), outs(), 32'd0);
        end

        run(1, 5, 0, 0, 1'b0);
        run(3, 2, 0, 0, 1'b0);
        run(0, 7, 0, 0, 1'b0);
        run(2, 0, 0, 0, 1'b0);
        run(2, 3, 3, 0, 1'b0);
        run(4, 1, 0, 6, 1'b0);
        run(1, 0, 0, 0, 1'b0);
        run(2, 1, 0, 0, 1'b1);
        run(3, 15, 0, 0, 1'b0);
        run(255, 0, 0, 0, 1'b0);

        for (int n = 0; n < 15; n++) begin
            run(int'($urandom_range(0, 6)), int'($urandom_range(0, 15)), 0, 0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
